// File: rtl/uart16550_cfg_master_if.sv
// ----------------------------------------------------------------------------
// uart16550_cfg_master_if
// Write-only AXI4-Lite bundle between uart16550_cfg_master and the UART16550
// s_axi_* slave port.
//   m_axi_aw* : write address channel (13-bit byte address)
//   m_axi_w*  : write data channel (32-bit data, 4-bit strobe)
//   m_axi_b*  : write response channel
// Modports: master (configuration sequencer side), slave (UART side).
// ----------------------------------------------------------------------------
interface uart16550_cfg_master_if;
   localparam int unsigned ADDR_W = 13;
   localparam int unsigned DATA_W = 32;

   logic [ADDR_W-1:0]   m_axi_awaddr;
   logic                m_axi_awvalid;
   logic                m_axi_awready;
   logic [DATA_W-1:0]   m_axi_wdata;
   logic [DATA_W/8-1:0] m_axi_wstrb;
   logic                m_axi_wvalid;
   logic                m_axi_wready;
   logic [1:0]          m_axi_bresp;
   logic                m_axi_bvalid;
   logic                m_axi_bready;

   modport master (
      output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb,
             m_axi_wvalid, m_axi_bready,
      input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
   );

   modport slave (
      input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb,
             m_axi_wvalid, m_axi_bready,
      output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid
   );
endinterface

// File: rtl/uart16550_cfg_master.sv
// ----------------------------------------------------------------------------
// uart16550_cfg_master
// Programs the UART16550 register block over AXI4-Lite from one start pulse:
// LCR(DLAB=1), DLL, DLM, LCR(DLAB=0), FCR, IER.
// Ports:
//   s_axi_aclk, s_axi_areset : clock, asynchronous active-high reset
//   cfg_start                : one-cycle request, accepted only when idle
//   cfg_wlen/stop2/parity_en/even, cfg_divisor, cfg_trig, cfg_ier : settings
//   m_axi                    : AXI4-Lite write master (uart16550_cfg_master_if)
//   cfg_busy, cfg_done, cfg_error : sequence status
// Optional feature: define UART_CFG_TIMEOUT_EN to abort any AW/W or B phase
// that stalls for TIMEOUT_CYCLES cycles (parameter exists only then).
// ----------------------------------------------------------------------------
module uart16550_cfg_master #(
   parameter logic [12:0] BASE_ADDR = 13'h1000
`ifdef UART_CFG_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 1023
`endif
) (
   input  logic                          s_axi_aclk,
   input  logic                          s_axi_areset,
   input  logic                          cfg_start,
   input  logic [1:0]                    cfg_wlen,
   input  logic                          cfg_stop2,
   input  logic                          cfg_parity_en,
   input  logic                          cfg_even,
   input  logic [15:0]                   cfg_divisor,
   input  logic [1:0]                    cfg_trig,
   input  logic [3:0]                    cfg_ier,
   uart16550_cfg_master_if.master        m_axi,
   output logic                          cfg_busy,
   output logic                          cfg_done,
   output logic                          cfg_error
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [2:0] LAST_STEP = 3'd5;
`ifdef UART_CFG_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
`endif

   logic [1:0]  state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic        aw_ok_q, aw_ok_d, w_ok_q, w_ok_d;
   logic [4:0]  lcr_q, lcr_d;
   logic [15:0] div_q, div_d;
   logic [1:0]  trig_q, trig_d;
   logic [3:0]  ier_q, ier_d;
   logic [12:0] awaddr_q, awaddr_d;
   logic        awvalid_q, awvalid_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  wstrb_q, wstrb_d;
   logic        wvalid_q, wvalid_d;
   logic        bready_q, bready_d;
   logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
   logic        aw_hs, w_hs, enter_write, issue, go_done;
`ifdef UART_CFG_TIMEOUT_EN
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tmo_hit;
`endif

   // Register offset for each step of the fixed 16550 programming order
   function automatic logic [12:0] beat_addr(input logic [2:0] s);
      case (s)
         3'd0, 3'd3: beat_addr = BASE_ADDR + 13'h00C;
         3'd1:       beat_addr = BASE_ADDR;
         3'd4:       beat_addr = BASE_ADDR + 13'h008;
         default:    beat_addr = BASE_ADDR + 13'h004;
      endcase
   endfunction

   // Register value for each step; lcr = {even, parity_en, stop2, wlen}
   function automatic logic [7:0] beat_data(input logic [2:0] s, input logic [4:0] lcr,
                                            input logic [15:0] div, input logic [1:0] trig,
                                            input logic [3:0] ier);
      case (s)
         3'd0:    beat_data = {1'b1, 2'b00, lcr};
         3'd1:    beat_data = div[7:0];
         3'd2:    beat_data = div[15:8];
         3'd3:    beat_data = {3'b000, lcr};
         3'd4:    beat_data = {trig, 6'b001111};
         default: beat_data = {4'b0000, ier};
      endcase
   endfunction

   // State and output registers
   always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
      if (s_axi_areset) begin
         state_q   <= S_IDLE;
         step_q    <= 3'd0;
         aw_ok_q   <= 1'b0;
         w_ok_q    <= 1'b0;
         lcr_q     <= 5'd0;
         div_q     <= 16'd0;
         trig_q    <= 2'd0;
         ier_q     <= 4'd0;
         awaddr_q  <= 13'd0;
         awvalid_q <= 1'b0;
         wdata_q   <= 32'd0;
         wstrb_q   <= 4'd0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
`ifdef UART_CFG_TIMEOUT_EN
         tmo_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         step_q    <= step_d;
         aw_ok_q   <= aw_ok_d;
         w_ok_q    <= w_ok_d;
         lcr_q     <= lcr_d;
         div_q     <= div_d;
         trig_q    <= trig_d;
         ier_q     <= ier_d;
         awaddr_q  <= awaddr_d;
         awvalid_q <= awvalid_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
`ifdef UART_CFG_TIMEOUT_EN
         tmo_q     <= tmo_d;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      aw_ok_d     = aw_ok_q;
      w_ok_d      = w_ok_q;
      lcr_d       = lcr_q;
      div_d       = div_q;
      trig_d      = trig_q;
      ier_d       = ier_q;
      awaddr_d    = awaddr_q;
      awvalid_d   = awvalid_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      wvalid_d    = wvalid_q;
      bready_d    = bready_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      enter_write = 1'b0;
      issue       = 1'b0;
      go_done     = 1'b0;
      aw_hs       = awvalid_q & m_axi.m_axi_awready;
      w_hs        = wvalid_q & m_axi.m_axi_wready;
`ifdef UART_CFG_TIMEOUT_EN
      tmo_d       = tmo_q + TW'(1);
      tmo_hit     = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`endif

      case (state_q)
         S_IDLE: begin
            if (cfg_start) begin
               lcr_d       = {cfg_even, cfg_parity_en, cfg_stop2, cfg_wlen};
               div_d       = cfg_divisor;
               trig_d      = cfg_trig;
               ier_d       = cfg_ier;
               error_d     = 1'b0;
               busy_d      = 1'b1;
               step_d      = 3'd0;
               enter_write = 1'b1;
               // A zero divisor enters WRITE with no valids and aborts there
               issue       = (cfg_divisor != 16'd0);
            end
         end
         S_WRITE: begin
            if (div_q == 16'd0) begin
               error_d = 1'b1;
               go_done = 1'b1;
            end else begin
               if (aw_hs) begin
                  awvalid_d = 1'b0;
                  aw_ok_d   = 1'b1;
               end
               if (w_hs) begin
                  wvalid_d = 1'b0;
                  wstrb_d  = 4'b0000;
                  w_ok_d   = 1'b1;
               end
               if ((aw_ok_q | aw_hs) && (w_ok_q | w_hs)) begin
                  state_d  = S_RESP;
                  bready_d = 1'b1;
`ifdef UART_CFG_TIMEOUT_EN
                  tmo_d    = '0;
               end else if (tmo_hit) begin
                  awvalid_d = 1'b0;
                  wvalid_d  = 1'b0;
                  wstrb_d   = 4'b0000;
                  error_d   = 1'b1;
                  go_done   = 1'b1;
`endif
               end
            end
         end
         S_RESP: begin
            if (m_axi.m_axi_bvalid) begin
               bready_d = 1'b0;
               if (m_axi.m_axi_bresp != 2'b00) begin
                  error_d = 1'b1;
                  go_done = 1'b1;
               end else if (step_q == LAST_STEP) begin
                  go_done = 1'b1;
               end else begin
                  step_d      = step_q + 3'd1;
                  enter_write = 1'b1;
                  issue       = 1'b1;
               end
`ifdef UART_CFG_TIMEOUT_EN
            end else if (tmo_hit) begin
               bready_d = 1'b0;
               error_d  = 1'b1;
               go_done  = 1'b1;
`endif
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Launch the beat for step_d; *_d settings are the freshly latched ones
      if (enter_write) begin
         state_d   = S_WRITE;
         aw_ok_d   = 1'b0;
         w_ok_d    = 1'b0;
         awvalid_d = issue;
         wvalid_d  = issue;
         wstrb_d   = issue ? 4'b0001 : 4'b0000;
         awaddr_d  = beat_addr(step_d);
         wdata_d   = {24'd0, beat_data(step_d, lcr_d, div_d, trig_d, ier_d)};
`ifdef UART_CFG_TIMEOUT_EN
         tmo_d     = '0;
`endif
      end

      if (go_done) begin
         state_d = S_DONE;
         done_d  = 1'b1;
         busy_d  = 1'b0;
      end
   end

   assign m_axi.m_axi_awaddr  = awaddr_q;
   assign m_axi.m_axi_awvalid = awvalid_q;
   assign m_axi.m_axi_wdata   = wdata_q;
   assign m_axi.m_axi_wstrb   = wstrb_q;
   assign m_axi.m_axi_wvalid  = wvalid_q;
   assign m_axi.m_axi_bready  = bready_q;
   assign cfg_busy            = busy_q;
   assign cfg_done            = done_q;
   assign cfg_error           = error_q;

endmodule

// File: tb/tb_uart16550_cfg_master.sv
// ----------------------------------------------------------------------------
// tb_uart16550_cfg_master
// Self-checking bench: a delay-configurable AXI-Lite slave, a write monitor,
// and a reference model that derives the expected register writes, counts,
// handshake durations and latency directly from the programming rules.
// ----------------------------------------------------------------------------
module tb_uart16550_cfg_master;

   typedef struct packed {
      logic [1:0]  wlen;
      logic        stop2;
      logic        par;
      logic        even;
      logic [15:0] div;
      logic [1:0]  trig;
      logic [3:0]  ier;
   } cfg_t;

   logic        clk;
   logic        rst;
   logic        cfg_start;
   logic [1:0]  cfg_wlen;
   logic        cfg_stop2;
   logic        cfg_parity_en;
   logic        cfg_even;
   logic [15:0] cfg_divisor;
   logic [1:0]  cfg_trig;
   logic [3:0]  cfg_ier;
   logic        cfg_busy;
   logic        cfg_done;
   logic        cfg_error;

   uart16550_cfg_master_if bus ();

   uart16550_cfg_master #(
      .BASE_ADDR(13'h1000)
`ifdef UART_CFG_TIMEOUT_EN
      , .TIMEOUT_CYCLES(15)
`endif
   ) dut (
      .s_axi_aclk   (clk),
      .s_axi_areset (rst),
      .cfg_start    (cfg_start),
      .cfg_wlen     (cfg_wlen),
      .cfg_stop2    (cfg_stop2),
      .cfg_parity_en(cfg_parity_en),
      .cfg_even     (cfg_even),
      .cfg_divisor  (cfg_divisor),
      .cfg_trig     (cfg_trig),
      .cfg_ier      (cfg_ier),
      .m_axi        (bus.master),
      .cfg_busy     (cfg_busy),
      .cfg_done     (cfg_done),
      .cfg_error    (cfg_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave behaviour knobs (written by the main sequence only)
   int aw_delay = 0, w_delay = 0, b_delay = 0, err_step = 7, seq_b_base = 0;
   bit w_never = 1'b0;

   // Monitor state (written by the monitor only)
   int aw_tot = 0, w_tot = 0, b_tot = 0, awv_cyc = 0, wv_cyc = 0, br_cyc = 0;
   logic [12:0] aw_log [1024];
   logic [31:0] w_log  [1024];
   logic [3:0]  s_log  [1024];

   always @(posedge clk) begin
      if (rst) begin
         // Forget half-finished transactions abandoned by reset
         aw_tot <= (aw_tot > w_tot) ? aw_tot : w_tot;
         w_tot  <= (aw_tot > w_tot) ? aw_tot : w_tot;
         b_tot  <= (aw_tot > w_tot) ? aw_tot : w_tot;
      end else begin
         if (bus.m_axi_awvalid) awv_cyc <= awv_cyc + 1;
         if (bus.m_axi_wvalid)  wv_cyc  <= wv_cyc + 1;
         if (bus.m_axi_bready)  br_cyc  <= br_cyc + 1;
         if (bus.m_axi_awvalid && bus.m_axi_awready) begin
            aw_log[aw_tot % 1024] <= bus.m_axi_awaddr;
            aw_tot <= aw_tot + 1;
         end
         if (bus.m_axi_wvalid && bus.m_axi_wready) begin
            w_log[w_tot % 1024] <= bus.m_axi_wdata;
            s_log[w_tot % 1024] <= bus.m_axi_wstrb;
            w_tot <= w_tot + 1;
         end
         if (bus.m_axi_bvalid && bus.m_axi_bready) b_tot <= b_tot + 1;
      end
   end

   // AXI-Lite slave: ready after N valid cycles, response N cycles after both
   initial begin
      int awc, wc, bc, pend;
      awc = 0; wc = 0; bc = 0;
      bus.m_axi_awready = 1'b0;
      bus.m_axi_wready  = 1'b0;
      bus.m_axi_bvalid  = 1'b0;
      bus.m_axi_bresp   = 2'b00;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.m_axi_awready = 1'b0;
            bus.m_axi_wready  = 1'b0;
            bus.m_axi_bvalid  = 1'b0;
            bus.m_axi_bresp   = 2'b00;
            awc = 0; wc = 0; bc = 0;
         end else begin
            if (bus.m_axi_awvalid) begin
               bus.m_axi_awready = (awc >= aw_delay);
               awc++;
            end else begin
               bus.m_axi_awready = 1'b0;
               awc = 0;
            end
            if (bus.m_axi_wvalid) begin
               bus.m_axi_wready = !w_never && (wc >= w_delay);
               wc++;
            end else begin
               bus.m_axi_wready = 1'b0;
               wc = 0;
            end
            pend = ((aw_tot < w_tot) ? aw_tot : w_tot) - b_tot;
            if (pend > 0) begin
               bus.m_axi_bvalid = (bc >= b_delay);
               bus.m_axi_bresp  = ((b_tot - seq_b_base) == err_step) ? 2'b10 : 2'b00;
               bc++;
            end else begin
               bus.m_axi_bvalid = 1'b0;
               bus.m_axi_bresp  = 2'b00;
               bc = 0;
            end
         end
      end
   end

   // Reference model: register address and value for write number s
   function automatic logic [12:0] exp_addr(input int s);
      int offs [6];
      offs = '{12, 0, 4, 12, 8, 4};
      return 13'(4096 + offs[s]);
   endfunction

   function automatic logic [7:0] exp_data(input cfg_t c, input int s);
      int lcr;
      lcr = int'(c.wlen) + 4 * int'(c.stop2) + 8 * int'(c.par) + 16 * int'(c.even);
      case (s)
         0:       return 8'(128 + lcr);
         1:       return 8'(int'(c.div) % 256);
         2:       return 8'(int'(c.div) / 256);
         3:       return 8'(lcr);
         4:       return 8'(64 * int'(c.trig) + 15);
         default: return 8'(c.ier);
      endcase
   endfunction

   task automatic drive_cfg(input cfg_t c);
      cfg_wlen      = c.wlen;
      cfg_stop2     = c.stop2;
      cfg_parity_en = c.par;
      cfg_even      = c.even;
      cfg_divisor   = c.div;
      cfg_trig      = c.trig;
      cfg_ier       = c.ier;
   endtask

   task automatic scramble_cfg();
      cfg_wlen      = 2'($urandom);
      cfg_stop2     = 1'($urandom);
      cfg_parity_en = 1'($urandom);
      cfg_even      = 1'($urandom);
      cfg_divisor   = 16'($urandom);
      cfg_trig      = 2'($urandom);
      cfg_ier       = 4'($urandom);
   endtask

   task automatic run_seq(input cfg_t c, input int awd, input int wd, input int bd,
                          input int es, input bit repulse);
      int n_exp, n, aw0, w0, b0, awv0, wv0, br0;
      bit got;
      aw_delay = awd; w_delay = wd; b_delay = bd; err_step = es;
      n_exp = (c.div == 16'd0) ? 0 : ((es <= 5) ? es + 1 : 6);
      @(negedge clk);
      drive_cfg(c);
      cfg_start = 1'b1;
      seq_b_base = b_tot;
      aw0 = aw_tot; w0 = w_tot; b0 = b_tot;
      awv0 = awv_cyc; wv0 = wv_cyc; br0 = br_cyc;
      @(posedge clk);
      #1 cfg_start = 1'b0;
      scramble_cfg();
      n = 0; got = 1'b0;
      while (!got && n < 3000) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            check("busy_after_start", 32'(cfg_busy), 32'd1);
            check("error_cleared", 32'(cfg_error), 32'd0);
         end
         if (repulse) cfg_start = (n == 4);
         if (cfg_done) got = 1'b1;
      end
      cfg_start = 1'b0;
      check("done_seen", 32'(got), 32'd1);
      if (awd == 0 && wd == 0 && bd == 0)
         check("done_latency", 32'(n), 32'((n_exp == 0) ? 2 : 2 * n_exp + 1));
      check("busy_at_done", 32'(cfg_busy), 32'd0);
      check("error_at_done", 32'(cfg_error), 32'((c.div == 16'd0 || es <= 5) ? 1 : 0));
      check("idle_channels", 32'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready}), 32'd0);
      @(negedge clk);
      check("done_pulse_width", 32'(cfg_done), 32'd0);
      check("aw_count", 32'(aw_tot - aw0), 32'(n_exp));
      check("w_count", 32'(w_tot - w0), 32'(n_exp));
      check("b_count", 32'(b_tot - b0), 32'(n_exp));
      check("awvalid_cycles", 32'(awv_cyc - awv0), 32'(n_exp * (awd + 1)));
      check("wvalid_cycles", 32'(wv_cyc - wv0), 32'(n_exp * (wd + 1)));
      check("bready_cycles", 32'(br_cyc - br0), 32'(n_exp * (bd + 1)));
      for (int k = 0; k < n_exp; k++) begin
         check($sformatf("awaddr_step%0d", k), 32'(aw_log[(aw0 + k) % 1024]), 32'(exp_addr(k)));
         check($sformatf("wdata_step%0d", k), w_log[(w0 + k) % 1024], {24'd0, exp_data(c, k)});
         check($sformatf("wstrb_step%0d", k), 32'(s_log[(w0 + k) % 1024]), 32'd1);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_status"}, 32'({cfg_busy, cfg_done, cfg_error,
             bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready}), 32'd0);
      check({tag, "_awaddr"}, 32'(bus.m_axi_awaddr), 32'd0);
      check({tag, "_wdata"}, bus.m_axi_wdata, 32'd0);
      check({tag, "_wstrb"}, 32'(bus.m_axi_wstrb), 32'd0);
   endtask

   initial begin
      cfg_t c;
      int n, b0;
      bit got;
      rst = 1'b1;
      cfg_start = 1'b0;
      c = '0;
      drive_cfg(c);
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      c.wlen = 2'b11; c.stop2 = 1'b0; c.par = 1'b0; c.even = 1'b0;
      c.div = 16'h0036; c.trig = 2'b10; c.ier = 4'b0111;
      run_seq(c, 0, 0, 0, 7, 1'b0);
      run_seq(c, 3, 0, 2, 7, 1'b0);
      run_seq(c, 0, 0, 0, 2, 1'b0);
      repeat (3) @(negedge clk);
      check("error_sticky", 32'(cfg_error), 32'd1);
      run_seq(c, 0, 0, 0, 7, 1'b0);
      c.div = 16'h0000;
      run_seq(c, 0, 0, 0, 7, 1'b0);
      c.div = 16'h0036;
      run_seq(c, 0, 0, 0, 7, 1'b1);

      // Asynchronous reset while step 3 is on the bus, then a fresh run
      aw_delay = 0; w_delay = 0; b_delay = 0; err_step = 7;
      @(negedge clk);
      drive_cfg(c);
      cfg_start = 1'b1;
      seq_b_base = b_tot;
      b0 = b_tot;
      @(posedge clk);
      #1 cfg_start = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         if (b_tot - b0 == 3) got = 1'b1;
      end
      check("reach_step3", 32'(got), 32'd1);
      check("step3_awvalid", 32'(bus.m_axi_awvalid), 32'd1);
      #2 rst = 1'b1;
      #1 check_all_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;
      run_seq(c, 0, 0, 0, 7, 1'b0);

      for (int i = 0; i < 24; i++) begin
         c.wlen = 2'($urandom); c.stop2 = 1'($urandom); c.par = 1'($urandom);
         c.even = 1'($urandom); c.trig = 2'($urandom); c.ier = 4'($urandom);
         c.div = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
         run_seq(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 7,
                 1'($urandom));
      end

`ifdef UART_CFG_TIMEOUT_EN
      begin
         int wcyc;
         w_never = 1'b1;
         aw_delay = 0; b_delay = 0; err_step = 7;
         c.div = 16'h0036;
         @(negedge clk);
         drive_cfg(c);
         cfg_start = 1'b1;
         @(posedge clk);
         #1 cfg_start = 1'b0;
         n = 0; wcyc = 0; got = 1'b0;
         while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.m_axi_wvalid) wcyc++;
            if (cfg_done) got = 1'b1;
         end
         check("tmo_done_seen", 32'(got), 32'd1);
         check("tmo_write_cycles", 32'(wcyc), 32'd15);
         check("tmo_error", 32'(cfg_error), 32'd1);
         check("tmo_valids", 32'({bus.m_axi_awvalid, bus.m_axi_wvalid, bus.m_axi_bready}), 32'd0);
         w_never = 1'b0;
         rst = 1'b1;
         repeat (2) @(negedge clk);
         rst = 1'b0;
      end
`endif

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
